// File: rtl/fetch_pc_gen.sv
// ----------------------------------------------------------------------------
// Module  : fetch_pc_gen
// Purpose : Fetch-stage PC register and next-PC select feeding the F/D stage.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_END   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stopen,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_en,
  input  logic [31:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] PC_out,
  output logic        adel_out,
  output logic        redirect_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    EXC  = 2'd1,
    ERET = 2'd2,
    BAD  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redirect;

  // Exception and eret override the stall: the pipeline is being flushed anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      state    <= RUN;
      redirect <= 1'b0;
    end else if (exc_req) begin
      pc       <= EXC_PC;
      state    <= EXC;
      redirect <= 1'b1;
    end else if (eret_req) begin
      pc       <= epc & 32'hFFFF_FFFC;
      state    <= ERET;
      redirect <= 1'b1;
    end else if (stopen) begin
      if (state == BAD) begin
        state    <= RUN;
        redirect <= 1'b0;
      end
    end else begin
      if (jmp_en)
        pc <= jmp_target;
      else if (br_taken)
        pc <= br_target;
      else
        pc <= pc + 32'd4;
      state    <= RUN;
      redirect <= 1'b0;
    end
  end

  assign PC_out       = pc;
  assign state_out    = state;
  assign redirect_out = redirect;
  assign adel_out     = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_END);

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
// ----------------------------------------------------------------------------
// Module  : tb_fetch_pc_gen
// Purpose : Directed plus randomized checks of fetch_pc_gen against a PC model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stopen = 1'b0, br_taken = 1'b0, jmp_en = 1'b0;
  logic        exc_req = 1'b0, eret_req = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0, epc = '0;
  logic [31:0] PC_out;
  logic        adel_out, redirect_out;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC and the "where did it come from" mode.
  logic [31:0] m_pc;
  int          m_mode;  // 0 run, 1 exception entry, 2 eret return

  fetch_pc_gen dut (
    .clk(clk), .reset(reset), .stopen(stopen),
    .br_taken(br_taken), .br_target(br_target),
    .jmp_en(jmp_en), .jmp_target(jmp_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .PC_out(PC_out), .adel_out(adel_out),
    .redirect_out(redirect_out), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_adel(input logic [31:0] p);
    return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6FFC);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, PC_out, m_pc);
    chk({tag, ".adel"}, {31'd0, adel_out}, {31'd0, exp_adel(m_pc)});
    chk({tag, ".state"}, {30'd0, state_out}, m_mode);
    chk({tag, ".redir"}, {31'd0, redirect_out}, {31'd0, m_mode != 0});
  endtask

  // One clock edge with the given inputs; model updated from the same inputs.
  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic e, input logic r, input logic [31:0] ep,
                      input string tag);
    stopen = s; br_taken = b; br_target = bt; jmp_en = j; jmp_target = jt;
    exc_req = e; eret_req = r; epc = ep;
    @(posedge clk);
    if (e) begin
      m_pc = 32'h4180; m_mode = 1;
    end else if (r) begin
      m_pc = {ep[31:2], 2'b00}; m_mode = 2;
    end else if (!s) begin
      m_pc   = j ? jt : (b ? bt : m_pc + 32'd4);
      m_mode = 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, tag);
  endtask

  initial begin
    m_pc = 32'h3000; m_mode = 0;
    #12;
    check_all("reset");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) idle("seq");
    chk("seq_end", PC_out, 32'h3010);

    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 32'h3100, 1'b0, '0, 1'b0, 1'b0, '0, "stall");
    chk("stall_hold", PC_out, 32'h3010);
    step(1'b0, 1'b1, 32'h3100, 1'b0, '0, 1'b0, 1'b0, '0, "br");
    chk("br_target", PC_out, 32'h3100);

    step(1'b0, 1'b0, '0, 1'b1, 32'h3020, 1'b0, 1'b0, '0, "jmp");
    step(1'b0, 1'b0, '0, 1'b1, 32'h3202, 1'b0, 1'b0, '0, "jmp_mis");
    chk("jmp_mis_adel", {31'd0, adel_out}, 32'd1);

    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, "exc_stall");
    chk("exc_pc", PC_out, 32'h4180);
    chk("exc_state", {30'd0, state_out}, 32'd1);
    idle("after_exc");
    chk("after_exc_pc", PC_out, 32'h4184);

    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h3047, "eret");
    chk("eret_pc", PC_out, 32'h3044);
    chk("eret_state", {30'd0, state_out}, 32'd2);

    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h3047, "exc_eret");
    chk("exc_eret_pc", PC_out, 32'h4180);
    step(1'b1, 1'b1, 32'h3000, 1'b1, 32'h3008, 1'b0, 1'b0, '0, "exc_stall_hold");
    step(1'b0, 1'b1, 32'h3400, 1'b1, 32'h3500, 1'b0, 1'b0, '0, "jmp_over_br");
    chk("jmp_over_br_pc", PC_out, 32'h3500);

    step(1'b0, 1'b0, '0, 1'b1, 32'h6FF0, 1'b0, 1'b0, '0, "near_end");
    for (int i = 0; i < 4; i++) idle("end_seq");
    chk("past_end_pc", PC_out, 32'h7000);
    chk("past_end_adel", {31'd0, adel_out}, 32'd1);

    step(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, "top");
    idle("wrap");
    chk("wrap_pc", PC_out, 32'h0);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    m_pc = 32'h3000; m_mode = 0;
    check_all("async_reset");
    #2 reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt, ep;
      bt = 32'h3000 + ($urandom_range(0, 4095) << 2);
      jt = 32'h2FF0 + $urandom_range(0, 16400);
      ep = $urandom();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, bt,
           $urandom_range(0, 5) == 0, jt,
           $urandom_range(0, 15) == 0, $urandom_range(0, 12) == 0, ep, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
